rx_os_sampler: RTL and testbench

Parametrised successor of the UART receive oversampling tick generator. It counts oversample enables, and the per-bit oversample ratio (OSR) is runtime-programmable rather than a fixed 13/16 choice. It emits mid-bit and bit-end ticks directly as single-cycle pulses, with no external edge detector. It also samples the synchronised RX line at mid-bit, optionally with 3-point majority voting and a noise flag. It sits between the baud-rate enable generator and the UART RX framing FSM.

---
 rtl/rx_os_sampler_pkg.sv | 11 +
 rtl/rx_maj3_voter.sv | 63 ++++++
 rtl/rx_os_sampler.sv | 90 +++++++++
 tb/tb_rx_os_sampler.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/rx_os_sampler_pkg.sv
// rx_os_sampler_pkg: shared UART receive constants and majority-of-3 helper
// Used by the oversampling tick generator, its voter and the TX loopback checker.
package rx_os_sampler_pkg;
    localparam int OSR_16      = 16;
    localparam int OSR_13      = 13;
    localparam int MIN_OSR_DEF = 4;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/rx_maj3_voter.sv
// rx_maj3_voter: mid-bit sample registers, 3-point vote and noise flag
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_clr             synchronous clear (drops samples and any pending result)
//   i_s0, i_s1, i_s2  en-qualified strobes for cnt == mid-1, mid, mid+1
//   i_rx              synchronised RX line
//   o_bit_valid       one-cycle pulse, o_bit_out/o_noise_flag valid
//   o_bit_out         voted (or single-sampled) bit
//   o_noise_flag      samples disagreed (0 when MAJ_EN = 0)
import rx_os_sampler_pkg::*;

module rx_maj3_voter #(
    parameter int MAJ_EN = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_s0,
    input  logic i_s1,
    input  logic i_s2,
    input  logic i_rx,
    output logic o_bit_valid,
    output logic o_bit_out,
    output logic o_noise_flag
);
    logic r_s0, r_s1, r_bit_valid, r_bit_out, r_noise_flag;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s0         <= 1'b0;
            r_s1         <= 1'b0;
            r_bit_valid  <= 1'b0;
            r_bit_out    <= 1'b0;
            r_noise_flag <= 1'b0;
        end else if (i_clr) begin
            r_s0         <= 1'b0;
            r_s1         <= 1'b0;
            r_bit_valid  <= 1'b0;
            r_bit_out    <= 1'b0;
            r_noise_flag <= 1'b0;
        end else begin
            r_bit_valid <= (MAJ_EN != 0) ? i_s2 : i_s1;
            if (i_s0)
                r_s0 <= i_rx;
            if (i_s1)
                r_s1 <= i_rx;
            // the third sample is taken straight from the line on its own strobe
            if (MAJ_EN != 0) begin
                if (i_s2) begin
                    r_bit_out    <= maj3(r_s0, r_s1, i_rx);
                    r_noise_flag <= !((r_s0 == r_s1) && (r_s1 == i_rx));
                end
            end else if (i_s1) begin
                r_bit_out    <= i_rx;
                r_noise_flag <= 1'b0;
            end
        end
    end

    assign o_bit_valid  = r_bit_valid;
    assign o_bit_out    = r_bit_out;
    assign o_noise_flag = r_noise_flag;
endmodule

// File: rtl/rx_os_sampler.sv
// rx_os_sampler: UART RX oversample counter with mid-bit/bit-end ticks and bit sampling
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_en           oversample enable from the baud generator
//   i_syn_clr      realign counter to a detected start edge (priority over i_en)
//   i_osr          requested oversamples per bit (0 means 2^CNT_W)
//   i_rx_in        synchronised RX line
//   o_mid_tick     pulse after the en cycle at cnt == mid
//   o_bit_end      pulse after the en cycle at cnt == osr_q-1
//   o_bit_valid    pulse, o_bit_out/o_noise_flag valid
//   o_bit_out      sampled bit
//   o_noise_flag   majority samples disagreed
import rx_os_sampler_pkg::*;

module rx_os_sampler #(
    parameter int CNT_W       = 5,
    parameter int DEFAULT_OSR = OSR_16,
    parameter int MIN_OSR     = MIN_OSR_DEF,
    parameter int MAJ_EN      = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_syn_clr,
    input  logic [CNT_W-1:0] i_osr,
    input  logic             i_rx_in,
    output logic             o_mid_tick,
    output logic             o_bit_end,
    output logic             o_bit_valid,
    output logic             o_bit_out,
    output logic             o_noise_flag
);
    localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_OSR);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt, r_osr_q, w_osr_cl, w_last, w_mid;
    logic             r_mid_tick, r_bit_end;
    logic             w_at_mid, w_at_last, w_at_pre, w_at_post;

    // 0 is legal (2^CNT_W); other values below the minimum fall back to the default
    assign w_osr_cl  = (i_osr != '0 && int'(i_osr) < MIN_OSR) ? DEF : i_osr;
    // osr_q == 0 wraps to all-ones, which is the last count for 2^CNT_W
    assign w_last    = r_osr_q - ONE;
    assign w_mid     = w_last >> 1;
    assign w_at_mid  = r_cnt == w_mid;
    assign w_at_last = r_cnt == w_last;
    assign w_at_pre  = r_cnt == w_mid - ONE;
    assign w_at_post = r_cnt == w_mid + ONE;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt      <= '0;
            r_osr_q    <= DEF;
            r_mid_tick <= 1'b0;
            r_bit_end  <= 1'b0;
        end else if (i_syn_clr) begin
            r_cnt      <= '0;
            r_osr_q    <= w_osr_cl;
            r_mid_tick <= 1'b0;
            r_bit_end  <= 1'b0;
        end else begin
            r_mid_tick <= i_en & w_at_mid;
            r_bit_end  <= i_en & w_at_last;
            if (i_en) begin
                r_cnt <= w_at_last ? '0 : r_cnt + ONE;
                // OSR only changes on a bit boundary
                if (w_at_last)
                    r_osr_q <= w_osr_cl;
            end
        end
    end

    rx_maj3_voter #(
        .MAJ_EN(MAJ_EN)
    ) u_voter (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clr       (i_syn_clr),
        .i_s0        (i_en & w_at_pre),
        .i_s1        (i_en & w_at_mid),
        .i_s2        (i_en & w_at_post),
        .i_rx        (i_rx_in),
        .o_bit_valid (o_bit_valid),
        .o_bit_out   (o_bit_out),
        .o_noise_flag(o_noise_flag)
    );

    assign o_mid_tick = r_mid_tick;
    assign o_bit_end  = r_bit_end;
endmodule

// File: tb/tb_rx_os_sampler.sv
// tb_rx_os_sampler: scoreboard bench for rx_os_sampler (voting and single-sample instances)
module tb_rx_os_sampler;
    typedef struct {
        int   cyc;
        logic mt, be, bv, bo, nf;
    } ev_t;

    logic       clk = 1'b0, rst = 1'b1, en = 1'b0, clr = 1'b0, rx = 1'b0;
    logic [4:0] osr = 5'd16;
    logic       mt_a, be_a, bv_a, bo_a, nf_a;
    logic       mt_b, be_b, bv_b, bo_b, nf_b;
    int         cyc = 0, n_vec = 0, n_bad = 0;
    ev_t        qa[$], qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rx_os_sampler #(.MAJ_EN(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_syn_clr(clr), .i_osr(osr), .i_rx_in(rx),
        .o_mid_tick(mt_a), .o_bit_end(be_a), .o_bit_valid(bv_a), .o_bit_out(bo_a), .o_noise_flag(nf_a)
    );

    rx_os_sampler #(.MAJ_EN(0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_syn_clr(clr), .i_osr(osr), .i_rx_in(rx),
        .o_mid_tick(mt_b), .o_bit_end(be_b), .o_bit_valid(bv_b), .o_bit_out(bo_b), .o_noise_flag(nf_b)
    );

    function automatic ev_t mk(input int c, input logic mt, be, bv, bo, nf);
        ev_t e;
        e.cyc = c; e.mt = mt; e.be = be; e.bv = bv; e.bo = bo; e.nf = nf;
        return e;
    endfunction

    task automatic cmp(input string nm, input ev_t e, input logic mt, be, bv, bo, nf);
        n_vec++;
        if (!(e.cyc == cyc && e.mt == mt && e.be == be && e.bv == bv &&
              (!e.bv || (e.bo == bo && e.nf == nf)))) begin
            n_bad++;
            $display("FAIL %s: got cyc=%0d mt=%0b be=%0b bv=%0b bo=%0b nf=%0b, expected cyc=%0d mt=%0b be=%0b bv=%0b bo=%0b nf=%0b",
                     nm, cyc, mt, be, bv, bo, nf, e.cyc, e.mt, e.be, e.bv, e.bo, e.nf);
        end
    endtask

    // monitor: every output pulse is matched against the next expected event
    always @(negedge clk) begin
        if (mt_a | be_a | bv_a) begin
            if (qa.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL maj_unexpected: got pulse at cyc=%0d mt=%0b be=%0b bv=%0b, expected none", cyc, mt_a, be_a, bv_a);
            end else cmp("maj_event", qa.pop_front(), mt_a, be_a, bv_a, bo_a, nf_a);
        end
        if (mt_b | be_b | bv_b) begin
            if (qb.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL single_unexpected: got pulse at cyc=%0d mt=%0b be=%0b bv=%0b, expected none", cyc, mt_b, be_b, bv_b);
            end else cmp("single_event", qb.pop_front(), mt_b, be_b, bv_b, bo_b, nf_b);
        end
    end

    task automatic chk_zero(input string nm, input logic [4:0] got);
        n_vec++;
        if (got !== 5'b0) begin
            n_bad++;
            $display("FAIL %s: outputs got %b, expected 00000", nm, got);
        end
    endtask

    task automatic step(input logic e, input logic c, input logic r);
        en = e; clr = c; rx = r;
        @(posedge clk);
        #2;
    endtask

    task automatic sync(input logic [4:0] o);
        osr = o;
        step(1'b0, 1'b1, 1'b0);
    endtask

    // drives en cycles for cnt 0..stop-1 of a bit of length n; expected events are hand-supplied
    task automatic run(input int n, input int mid, input int gap, input int stop, input logic [31:0] rv,
                       input logic bo, input logic nf, input logic bo0, input int chg_at, input logic [4:0] chg_val);
        for (int c = 0; c < stop; c++) begin
            if (c == chg_at) osr = chg_val;
            repeat (gap) step(1'b0, 1'b0, rv[c]);
            step(1'b1, 1'b0, rv[c]);
            if (c == mid) begin
                qa.push_back(mk(cyc, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
                qb.push_back(mk(cyc, 1'b1, 1'b0, 1'b1, bo0, 1'b0));
            end
            if (c == mid + 1) qa.push_back(mk(cyc, 1'b0, 1'b0, 1'b1, bo, nf));
            if (c == n - 1) begin
                qa.push_back(mk(cyc, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
                qb.push_back(mk(cyc, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
            end
        end
    endtask

    initial begin
        #3;
        chk_zero("reset_maj", {mt_a, be_a, bv_a, bo_a, nf_a});
        chk_zero("reset_single", {mt_b, be_b, bv_b, bo_b, nf_b});
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        // osr 16, en every 4th clock, line low
        sync(5'd16);
        run(16, 7, 3, 16, 32'h0, 1'b0, 1'b0, 1'b0, -1, 5'd0);
        run(16, 7, 3, 16, 32'h0, 1'b0, 1'b0, 1'b0, -1, 5'd0);
        // osr 13 back to back, then a request for 16 mid-bit
        sync(5'd13);
        run(13, 6, 0, 13, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, -1, 5'd0);
        run(13, 6, 0, 13, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 3, 5'd16);
        run(16, 7, 0, 16, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, -1, 5'd0);
        // glitch on the middle sample
        sync(5'd16);
        run(16, 7, 0, 16, 32'hFFFF_FF7F, 1'b1, 1'b1, 1'b0, -1, 5'd0);
        // syn_clr with en at cnt 7 suppresses the tick and the sample
        sync(5'd16);
        run(16, 7, 0, 7, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, -1, 5'd0);
        step(1'b1, 1'b1, 1'b1);
        run(16, 7, 0, 16, 32'h0, 1'b0, 1'b0, 1'b0, -1, 5'd0);
        // illegal osr 2 -> 16, then osr 0 -> 32
        sync(5'd2);
        run(16, 7, 1, 16, 32'h0000_0100, 1'b0, 1'b1, 1'b0, -1, 5'd0);
        sync(5'd0);
        run(32, 15, 0, 32, 32'hFFFF_BFFF, 1'b1, 1'b1, 1'b1, -1, 5'd0);
        // async reset during the cnt 7 en cycle of an osr 13 bit
        sync(5'd13);
        run(13, 6, 0, 7, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, -1, 5'd0);
        en = 1'b1; rx = 1'b1;
        #5;
        rst = 1'b1;
        #1;
        chk_zero("async_rst_maj", {mt_a, be_a, bv_a, bo_a, nf_a});
        chk_zero("async_rst_single", {mt_b, be_b, bv_b, bo_b, nf_b});
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        run(16, 7, 0, 16, 32'h0000_0180, 1'b1, 1'b1, 1'b1, -1, 5'd0);
        run(13, 6, 0, 13, 32'h0, 1'b0, 1'b0, 1'b0, -1, 5'd0);
        repeat (6) step(1'b0, 1'b0, 1'b0);
        n_vec++;
        if (qa.size() != 0) begin
            n_bad++;
            $display("FAIL maj_missing: got %0d events unmatched, expected 0 (first cyc=%0d)", qa.size(), qa[0].cyc);
        end
        n_vec++;
        if (qb.size() != 0) begin
            n_bad++;
            $display("FAIL single_missing: got %0d events unmatched, expected 0 (first cyc=%0d)", qb.size(), qb[0].cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
